// File: rtl/proc_pkg.sv
// Shared processor definitions: instruction field layout, opcodes, ALU function
// codes and the issue-stage buffer state encoding.
package proc_pkg;

   localparam int OP_HI = 31, OP_LO = 26;
   localparam int RS_HI = 25, RS_LO = 21;
   localparam int RT_HI = 20, RT_LO = 16;
   localparam int RD_HI = 15, RD_LO = 11;
   localparam int SH_HI = 10, SH_LO = 6;
   localparam int FN_HI = 5,  FN_LO = 0;

   localparam logic [5:0] OP_RTYPE = 6'h03;

   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_SUB  = 6'h24;
   localparam logic [5:0] F_AND  = 6'h14;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLTU = 6'h2a;
   localparam logic [5:0] F_SLT  = 6'h2b;
   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;

   typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} buf_state_t;

   // R-type writes rd, everything else writes rt
   function automatic logic [4:0] dest_reg(input logic [31:0] ins);
      return (ins[OP_HI:OP_LO] == OP_RTYPE) ? ins[RD_HI:RD_LO] : ins[RT_HI:RT_LO];
   endfunction

endpackage

// File: rtl/ex_issue_if.sv
// Issue-stage bus: upstream handshake, forwarding sources, downstream ALU handshake.
// master = environment side, slave = ex_issue_stage.
interface ex_issue_if #(parameter int DW = 32);
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_instruction;
   logic [DW-1:0] in_rs_data;
   logic [DW-1:0] in_rt_data;
   logic          ex_wr_en;
   logic [4:0]    ex_wr_reg;
   logic [DW-1:0] ex_wr_data;
   logic          ex_wr_pending;
   logic          mem_wr_en;
   logic [4:0]    mem_wr_reg;
   logic [DW-1:0] mem_wr_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_instruction;
   logic [DW-1:0] out_r1;
   logic [DW-1:0] out_r2;
   logic [4:0]    out_wr_reg;
   logic          out_wr_en;

   modport master (
      output flush, in_valid, in_instruction, in_rs_data, in_rt_data,
             ex_wr_en, ex_wr_reg, ex_wr_data, ex_wr_pending,
             mem_wr_en, mem_wr_reg, mem_wr_data, out_ready,
      input  in_ready, out_valid, out_instruction, out_r1, out_r2, out_wr_reg, out_wr_en
   );

   modport slave (
      input  flush, in_valid, in_instruction, in_rs_data, in_rt_data,
             ex_wr_en, ex_wr_reg, ex_wr_data, ex_wr_pending,
             mem_wr_en, mem_wr_reg, mem_wr_data, out_ready,
      output in_ready, out_valid, out_instruction, out_r1, out_r2, out_wr_reg, out_wr_en
   );
endinterface

// File: rtl/operand_fwd_mux.sv
// Resolves one source operand against the EX/MEM writers.
// EX_ISSUE_FWD_EN selects forwarding; otherwise any writer match stalls.
module operand_fwd_mux #(
   parameter int DW = 32
) (
   input  logic [4:0]    src,
   input  logic [DW-1:0] rf_data,
   input  logic          ex_wr_en,
   input  logic [4:0]    ex_wr_reg,
   input  logic [DW-1:0] ex_wr_data,
   input  logic          ex_wr_pending,
   input  logic          mem_wr_en,
   input  logic [4:0]    mem_wr_reg,
   input  logic [DW-1:0] mem_wr_data,
   output logic [DW-1:0] data,
   output logic          hazard
);
   logic src_nz, ex_hit, mem_hit;

   assign src_nz  = (src != 5'd0);
   assign ex_hit  = src_nz && ex_wr_en  && (ex_wr_reg  == src);
   assign mem_hit = src_nz && mem_wr_en && (mem_wr_reg == src);

`ifdef EX_ISSUE_FWD_EN
   // a pending EX result shadows any older MEM value, so it must stall
   assign hazard = ex_hit && ex_wr_pending;

   always_comb begin
      data = rf_data;
      if (!src_nz)      data = '0;
      else if (ex_hit)  data = ex_wr_data;
      else if (mem_hit) data = mem_wr_data;
   end
`else
   logic unused_ok;
   assign unused_ok = ^{ex_wr_data, ex_wr_pending, mem_wr_data};

   assign hazard = ex_hit || mem_hit;
   assign data   = src_nz ? rf_data : '0;
`endif

endmodule

// File: rtl/ex_issue_stage.sv
// Issue register ahead of the EX ALU: operand forwarding / load-use stall plus a
// two-entry skid buffer. Optional forwarding via EX_ISSUE_FWD_EN.
module ex_issue_stage
   import proc_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic    clk,
   input  logic    rst,
   ex_issue_if.slave bus
);
   typedef struct packed {
      logic [DW-1:0] ins;
      logic [DW-1:0] r1;
      logic [DW-1:0] r2;
      logic [4:0]    wr_reg;
      logic          wr_en;
   } entry_t;

   buf_state_t    state;
   entry_t        out_q, skid_q, nxt;
   logic [DW-1:0] r1_res, r2_res;
   logic          hz_rs, hz_rt, hazard, ready, accept, fire;
   logic [4:0]    dst;

   operand_fwd_mux #(.DW(DW)) u_fwd_rs (
      .src          (bus.in_instruction[RS_HI:RS_LO]),
      .rf_data      (bus.in_rs_data),
      .ex_wr_en     (bus.ex_wr_en),
      .ex_wr_reg    (bus.ex_wr_reg),
      .ex_wr_data   (bus.ex_wr_data),
      .ex_wr_pending(bus.ex_wr_pending),
      .mem_wr_en    (bus.mem_wr_en),
      .mem_wr_reg   (bus.mem_wr_reg),
      .mem_wr_data  (bus.mem_wr_data),
      .data         (r1_res),
      .hazard       (hz_rs)
   );

   operand_fwd_mux #(.DW(DW)) u_fwd_rt (
      .src          (bus.in_instruction[RT_HI:RT_LO]),
      .rf_data      (bus.in_rt_data),
      .ex_wr_en     (bus.ex_wr_en),
      .ex_wr_reg    (bus.ex_wr_reg),
      .ex_wr_data   (bus.ex_wr_data),
      .ex_wr_pending(bus.ex_wr_pending),
      .mem_wr_en    (bus.mem_wr_en),
      .mem_wr_reg   (bus.mem_wr_reg),
      .mem_wr_data  (bus.mem_wr_data),
      .data         (r2_res),
      .hazard       (hz_rt)
   );

   assign hazard = hz_rs || hz_rt;
   // ready depends only on the registered skid flag and the operand hazard
   assign ready  = (state != ST_FULL) && !hazard;
   assign accept = bus.in_valid && ready;
   assign fire   = (state != ST_EMPTY) && bus.out_ready;

   assign dst        = dest_reg(bus.in_instruction[31:0]);
   assign nxt.ins    = bus.in_instruction;
   assign nxt.r1     = r1_res;
   assign nxt.r2     = r2_res;
   assign nxt.wr_reg = dst;
   assign nxt.wr_en  = (dst != 5'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_EMPTY;
         out_q  <= '0;
         skid_q <= '0;
      end else if (bus.flush) begin
         state <= ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: if (accept) begin
               out_q <= nxt;
               state <= ST_ONE;
            end
            ST_ONE: begin
               if (accept && fire) out_q <= nxt;
               else if (accept) begin
                  skid_q <= nxt;
                  state  <= ST_FULL;
               end else if (fire) state <= ST_EMPTY;
            end
            ST_FULL: if (fire) begin
               out_q <= skid_q;
               state <= ST_ONE;
            end
            default: state <= ST_EMPTY;
         endcase
      end
   end

   assign bus.in_ready        = ready;
   assign bus.out_valid       = (state != ST_EMPTY);
   assign bus.out_instruction = out_q.ins;
   assign bus.out_r1          = out_q.r1;
   assign bus.out_r2          = out_q.r2;
   assign bus.out_wr_reg      = out_q.wr_reg;
   assign bus.out_wr_en       = out_q.wr_en;

endmodule
